// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO read-side logic.
package fifo_pkg;

    // Default data width of the FIFO words.
    localparam int FIFO_DSIZE = 8;

    // Fill level of the two-entry output buffer.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream carrying FIFO words and a packet-end marker.
interface fifo_rd_stream_if
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE
);

    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry buffer with its occupancy state machine. Entries are written at the tail on
// push and leave from the head on pop; push is never asserted while the buffer is full.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output occ_e             occ,
    output logic             valid,
    output logic [DSIZE-1:0] head
);

    occ_e             occ_q, occ_d;
    logic             valid_q, valid_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] tail_q, tail_d;

    // Next buffer contents and occupancy from the push/pop pair.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    occ_d  = OCC_ONE;
                    head_d = push_data;
                end
            end
            OCC_ONE: begin
                if (push && !pop) begin
                    occ_d  = OCC_TWO;
                    tail_d = push_data;
                end else if (!push && pop) begin
                    occ_d  = OCC_EMPTY;
                end else if (push && pop) begin
                    head_d = push_data;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    occ_d  = OCC_ONE;
                    head_d = tail_q;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
        valid_d = (occ_d != OCC_EMPTY);
    end

    // Register occupancy, the registered valid flag and both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= OCC_EMPTY;
            valid_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            occ_q   <= occ_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign occ   = occ_q;
    assign valid = valid_q;
    assign head  = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: fetches words into a two-entry buffer and presents them as a
// valid/ready stream with packet-end tagging and a delivered-beat counter. The FIFO pop
// depends only on buffer occupancy, never on m_ready.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DSIZE   = FIFO_DSIZE,
    parameter int PKT_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  enable,
    input  logic [DSIZE-1:0]      fifo_rdata,
    input  logic                  fifo_rempty,
    output logic                  fifo_rinc,
    fifo_rd_stream_if.master      m,
    output logic [CNT_W-1:0]      word_cnt
);

    localparam int              BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    occ_e              occ;
    logic              buf_valid;
    logic [DSIZE-1:0]  buf_head;
    logic              pop;

    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

    // Fetch whenever enabled, data is available and the buffer has a free slot.
    always_comb begin
        fifo_rinc = enable & ~fifo_rempty & (occ != OCC_TWO) & ~rrst;
    end

    assign pop = buf_valid & m.m_ready;

    skid_buf2 #(
        .DSIZE (DSIZE)
    ) u_buf (
        .clk       (rclk),
        .rst       (rrst),
        .push      (fifo_rinc),
        .push_data (fifo_rdata),
        .pop       (pop),
        .occ       (occ),
        .valid     (buf_valid),
        .head      (buf_head)
    );

    // Advance the packet position and the delivered-word count on each handshake.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        word_cnt_d = word_cnt_q;
        if (pop) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (beat_cnt_q == BEAT_LAST) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
        end
    end

    // Counter registers; reset restarts packet alignment at beat 0.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign m.m_valid = buf_valid;
    assign m.m_data  = buf_head;
    assign m.m_last  = buf_valid & (beat_cnt_q == BEAT_LAST);
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with PKT_LEN=4 and a small behavioural FIFO model.
module tb_fifo_rd_stream;

    localparam int DSIZE   = 8;
    localparam int PKT_LEN = 4;
    localparam int CNT_W   = 16;

    logic             rclk;
    logic             rrst;
    logic             enable;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [CNT_W-1:0] word_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO: bench writes at wr_ptr, the DUT pops at rd_ptr.
    logic [DSIZE-1:0] fifo_mem [64];
    logic [5:0]       rd_ptr = '0;
    logic [5:0]       wr_ptr = '0;

    fifo_rd_stream_if #(.DSIZE(DSIZE)) m_if ();

    fifo_rd_stream #(
        .DSIZE   (DSIZE),
        .PKT_LEN (PKT_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .rclk        (rclk),
        .rrst        (rrst),
        .enable      (enable),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_rinc   (fifo_rinc),
        .m           (m_if.master),
        .word_cnt    (word_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    assign fifo_rdata  = fifo_mem[rd_ptr];
    assign fifo_rempty = (rd_ptr == wr_ptr);

    // FIFO read pointer advances on each pop.
    always @(posedge rclk) begin
        if (fifo_rinc) rd_ptr <= rd_ptr + 6'd1;
    end

    task automatic push_word(input logic [DSIZE-1:0] d);
        fifo_mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic apply_stimulus(input logic rst_v, input logic en_v, input logic rdy_v);
        rrst = rst_v;
        enable = en_v;
        m_if.m_ready = rdy_v;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) fifo_mem[i] = '0;

        // 1: reset with data available and fetching enabled
        apply_stimulus(1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) push_word(DSIZE'(i));
        @(negedge rclk);
        @(negedge rclk);
        check_output("rst_rinc", 32'(fifo_rinc), 0);
        check_output("rst_valid", 32'(m_if.m_valid), 0);
        check_output("rst_wcnt", 32'(word_cnt), 0);
        check_output("rst_data", 32'(m_if.m_data), 0);
        check_output("rst_last", 32'(m_if.m_last), 0);

        // 2: stream 01..05 with m_ready held high
        apply_stimulus(1'b0, 1'b1, 1'b1);
        #1;
        check_output("t2_rinc_first", 32'(fifo_rinc), 1);
        check_output("t2_valid_before", 32'(m_if.m_valid), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge rclk);
            check_output("t2_valid", 32'(m_if.m_valid), 1);
            check_output("t2_data", 32'(m_if.m_data), 32'(i + 1));
            check_output("t2_last", 32'(m_if.m_last), (i == 3) ? 1 : 0);
        end
        @(negedge rclk);
        check_output("t2_valid_end", 32'(m_if.m_valid), 0);
        check_output("t2_wcnt", 32'(word_cnt), 5);
        check_output("t2_rinc_end", 32'(fifo_rinc), 0);

        // 3: backpressure with three words available
        apply_stimulus(1'b0, 1'b1, 1'b0);
        push_word(8'h11);
        push_word(8'h12);
        push_word(8'h13);
        #1;
        check_output("t3_rinc0", 32'(fifo_rinc), 1);
        @(negedge rclk);
        check_output("t3_data_a", 32'(m_if.m_data), 32'h11);
        check_output("t3_rinc1", 32'(fifo_rinc), 1);
        @(negedge rclk);
        check_output("t3_data_b", 32'(m_if.m_data), 32'h11);
        check_output("t3_rinc_full", 32'(fifo_rinc), 0);
        @(negedge rclk);
        check_output("t3_data_hold", 32'(m_if.m_data), 32'h11);
        check_output("t3_rinc_hold", 32'(fifo_rinc), 0);
        check_output("t3_last_hold", 32'(m_if.m_last), 0);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        @(negedge rclk);
        check_output("t3_data_12", 32'(m_if.m_data), 32'h12);
        check_output("t3_rinc_refill", 32'(fifo_rinc), 1);
        @(negedge rclk);
        check_output("t3_data_13", 32'(m_if.m_data), 32'h13);
        check_output("t3_last_13", 32'(m_if.m_last), 1);
        @(negedge rclk);
        check_output("t3_valid_end", 32'(m_if.m_valid), 0);
        check_output("t3_wcnt", 32'(word_cnt), 8);

        // 4: reset, then ten words with packet boundaries on beats 3 and 7
        apply_stimulus(1'b1, 1'b1, 1'b1);
        @(negedge rclk);
        check_output("t4_rst_wcnt", 32'(word_cnt), 0);
        check_output("t4_rst_valid", 32'(m_if.m_valid), 0);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) push_word(DSIZE'(8'h20 + i));
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            check_output("t4_data", 32'(m_if.m_data), 32'(8'h20 + i));
            check_output("t4_last", 32'(m_if.m_last), (i == 3 || i == 7) ? 1 : 0);
        end
        @(negedge rclk);
        check_output("t4_valid_end", 32'(m_if.m_valid), 0);
        check_output("t4_wcnt", 32'(word_cnt), 10);

        // 5: enable dropped after the second fetch
        for (int i = 0; i < 5; i++) push_word(DSIZE'(8'h30 + i));
        @(negedge rclk);
        check_output("t5_data_30", 32'(m_if.m_data), 32'h30);
        @(negedge rclk);
        check_output("t5_data_31", 32'(m_if.m_data), 32'h31);
        check_output("t5_last_31", 32'(m_if.m_last), 1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        #1;
        check_output("t5_rinc_off", 32'(fifo_rinc), 0);
        @(negedge rclk);
        check_output("t5_valid_a", 32'(m_if.m_valid), 0);
        check_output("t5_rinc_a", 32'(fifo_rinc), 0);
        @(negedge rclk);
        check_output("t5_valid_b", 32'(m_if.m_valid), 0);
        check_output("t5_rinc_b", 32'(fifo_rinc), 0);
        check_output("t5_wcnt", 32'(word_cnt), 12);

        // 6: reset while the buffer is full; 32..34 remain in the FIFO
        apply_stimulus(1'b0, 1'b1, 1'b1);
        @(negedge rclk);
        check_output("t6_data_32", 32'(m_if.m_data), 32'h32);
        @(negedge rclk);
        check_output("t6_data_33", 32'(m_if.m_data), 32'h33);
        check_output("t6_last_33", 32'(m_if.m_last), 0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        @(negedge rclk);
        check_output("t6_full_valid", 32'(m_if.m_valid), 1);
        check_output("t6_full_rinc", 32'(fifo_rinc), 0);
        check_output("t6_full_data", 32'(m_if.m_data), 32'h33);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        #1;
        check_output("t6_rst_rinc", 32'(fifo_rinc), 0);
        @(negedge rclk);
        check_output("t6_rst_valid", 32'(m_if.m_valid), 0);
        check_output("t6_rst_wcnt", 32'(word_cnt), 0);
        check_output("t6_rst_data", 32'(m_if.m_data), 0);
        check_output("t6_rst_last", 32'(m_if.m_last), 0);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) push_word(DSIZE'(8'h40 + i));
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            check_output("t6_data", 32'(m_if.m_data), 32'(8'h40 + i));
            check_output("t6_last", 32'(m_if.m_last), (i == 3) ? 1 : 0);
        end
        @(negedge rclk);
        check_output("t6_valid_end", 32'(m_if.m_valid), 0);
        check_output("t6_wcnt", 32'(word_cnt), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
